regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader_if.sv | 33 +++
 rtl/regfile_dump_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready stream that carries one register value per beat,
// tagged with its index. The beat can also be flagged as last, or as the checksum beat.
interface regfile_dump_reader_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned INDEX     = 5
);
    logic                 m_valid;
    logic                 m_ready;
    logic [DATAWIDTH-1:0] m_data;
    logic [INDEX-1:0]     m_index;
    logic                 m_last;
    logic                 m_is_csum;

    // The dump reader produces beats.
    modport master (
        output m_valid,
        output m_data,
        output m_index,
        output m_last,
        output m_is_csum,
        input  m_ready
    );

    // The debug transport consumes beats.
    modport slave (
        input  m_valid,
        input  m_data,
        input  m_index,
        input  m_last,
        input  m_is_csum,
        output m_ready
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: after a start pulse, reads every register of the regfile through
// one spare read port. Each value goes out as one indexed beat on a valid/ready stream.
// Each register is sampled in its own READ cycle, so the dump is a rolling snapshot.
// Optional feature: define REGFILE_DUMP_CSUM_EN to add one more beat that carries the
// XOR of all captured values.
module regfile_dump_reader #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned REGISTERS = 32,
    parameter int unsigned INDEX     = $clog2(REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [INDEX-1:0]      ra,
    input  logic [DATAWIDTH-1:0]  rd,
    regfile_dump_reader_if.master m
);

    // Compare against the last index explicitly, so a REGISTERS value that is not a
    // power of two works without relying on wrap-around.
    localparam logic [INDEX-1:0] LastIdx = INDEX'(REGISTERS - 1);

`ifdef REGFILE_DUMP_CSUM_EN
    localparam logic CsumOn = 1'b1;
`else
    localparam logic CsumOn = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StSend,
`ifdef REGFILE_DUMP_CSUM_EN
        StCsum,
`endif
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [INDEX-1:0]     index_q, index_d;
    logic                 m_valid_q, m_valid_d;
    logic [DATAWIDTH-1:0] m_data_q, m_data_d;
    logic [INDEX-1:0]     m_index_q, m_index_d;
    logic                 m_last_q, m_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATAWIDTH-1:0] csum_q, csum_d;
    logic                 m_is_csum_q, m_is_csum_d;
`endif

    logic handshake;
    assign handshake = m_valid_q & m.m_ready;

    // Next-state logic: walk the indices and load the output beat registers.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
`ifdef REGFILE_DUMP_CSUM_EN
        csum_d      = csum_q;
        m_is_csum_d = m_is_csum_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    index_d = '0;
`ifdef REGFILE_DUMP_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end

            StRead: begin
                // rd is combinational from ra, so it is captured in the same cycle.
                m_data_d  = rd;
                m_index_d = index_q;
                m_last_d  = (index_q == LastIdx) && !CsumOn;
                m_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
                csum_d      = csum_q ^ rd;
                m_is_csum_d = 1'b0;
`endif
                state_d   = StSend;
            end

            StSend: begin
                if (handshake) begin
                    m_valid_d = 1'b0;
                    if (index_q == LastIdx) begin
`ifdef REGFILE_DUMP_CSUM_EN
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        index_d = index_q + INDEX'(1);
                        state_d = StRead;
                    end
                end
            end

`ifdef REGFILE_DUMP_CSUM_EN
            StCsum: begin
                // First cycle in this state loads the checksum beat. After that the state
                // waits for the handshake in the same way as SEND.
                if (!m_valid_q) begin
                    m_data_d    = csum_q;
                    m_index_d   = '0;
                    m_last_d    = 1'b1;
                    m_is_csum_d = 1'b1;
                    m_valid_d   = 1'b1;
                end else if (m.m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = StDone;
                end
            end
`endif

            StDone: begin
                m_valid_d = 1'b0;
                state_d   = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // busy and done are registered copies of the next state, so they line up with it.
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and output registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            index_q     <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_index_q   <= '0;
            m_last_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            csum_q      <= '0;
            m_is_csum_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_index_q   <= m_index_d;
            m_last_q    <= m_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef REGFILE_DUMP_CSUM_EN
            csum_q      <= csum_d;
            m_is_csum_q <= m_is_csum_d;
`endif
        end
    end

    assign ra          = index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign m.m_valid   = m_valid_q;
    assign m.m_data    = m_data_q;
    assign m.m_index   = m_index_q;
    assign m.m_last    = m_last_q;
`ifdef REGFILE_DUMP_CSUM_EN
    assign m.m_is_csum = m_is_csum_q;
`else
    assign m.m_is_csum = 1'b0;
`endif

endmodule
